// File: rtl/alu_req_arbiter_if.sv
// Bundle of the two command ports, the two response channels and the ALU operand/result bus
// that sit around the alu_req_arbiter controller.
interface alu_req_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
);
    logic             REQ0_VALID, REQ1_VALID;
    logic             REQ0_READY, REQ1_READY;
    logic [WIDTH-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [FUN_W-1:0] REQ0_FUN, REQ1_FUN;
    logic             RSP0_VALID, RSP1_VALID;
    logic             RSP0_READY, RSP1_READY;
    logic [WIDTH-1:0] RSP_DATA;
    logic [4:0]       RSP_FLAGS;
    logic             RSP_ERR;
    logic [WIDTH-1:0] ALU_A, ALU_B;
    logic [FUN_W-1:0] ALU_FUN;
    logic [WIDTH-1:0] ALU_OUT;
    logic             ALU_CARRY, ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT;
    logic             BUSY;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_FUN, REQ1_FUN,
        input  RSP0_READY, RSP1_READY,
        input  ALU_OUT, ALU_CARRY, ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT,
        output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR,
        output ALU_A, ALU_B, ALU_FUN, BUSY
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_FUN, REQ1_FUN,
        output RSP0_READY, RSP1_READY,
        output ALU_OUT, ALU_CARRY, ALU_ARITH, ALU_LOGIC, ALU_CMP, ALU_SHIFT,
        input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR,
        input  ALU_A, ALU_B, ALU_FUN, BUSY
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin front end for the registered 16-bit ALU: grants one of two command ports,
// runs a single operation through the ALU and returns the captured result on a response channel.
module alu_req_arbiter #(
    parameter int               WIDTH   = 16,
    parameter int               FUN_W   = 4,
    parameter logic [FUN_W-1:0] NOP_FUN = 4'b1111
) (
    input  logic             CLK,
    input  logic             RST,
    alu_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    localparam logic [FUN_W-1:0] FUN_ADD = FUN_W'(0);
    localparam logic [FUN_W-1:0] FUN_SUB = FUN_W'(1);
    localparam logic [FUN_W-1:0] FUN_DIV = FUN_W'(3);
    localparam logic [FUN_W-1:0] FUN_BAD = FUN_W'(15);

    state_t           state, state_nxt;
    logic             last, owner;
    logic             gnt, gnt_vld, sel_err, rsp_ack, carry_m;
    logic             ready0, ready1;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [FUN_W-1:0] sel_fun;
    logic [WIDTH-1:0] alu_a, alu_b, rsp_data;
    logic [FUN_W-1:0] alu_fun;
    logic [4:0]       rsp_flags;
    logic             rsp_err, rsp0_valid, rsp1_valid;

    // With both ports pending, the one not served last wins; a lone requester always wins.
    assign gnt_vld = bus.REQ0_VALID | bus.REQ1_VALID;
    assign gnt     = (bus.REQ0_VALID & bus.REQ1_VALID) ? ~last : bus.REQ1_VALID;
    assign sel_a   = gnt ? bus.REQ1_A   : bus.REQ0_A;
    assign sel_b   = gnt ? bus.REQ1_B   : bus.REQ0_B;
    assign sel_fun = gnt ? bus.REQ1_FUN : bus.REQ0_FUN;
    assign sel_err = ((sel_fun == FUN_DIV) && (sel_b == '0)) || (sel_fun == FUN_BAD);
    assign rsp_ack = owner ? bus.RSP1_READY : bus.RSP0_READY;

    // The ALU keeps its carry from the last add/sub; only those two opcodes report it.
    assign carry_m = ((alu_fun == FUN_ADD) || (alu_fun == FUN_SUB)) ? bus.ALU_CARRY : 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state)
            IDLE: begin
                ready0 = gnt_vld & ~gnt;
                ready1 = gnt_vld & gnt;
                if (gnt_vld) state_nxt = sel_err ? RESP : EXEC;
            end
            EXEC:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (rsp_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fun    <= NOP_FUN;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last       <= 1'b1;
            owner      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        owner <= gnt;
                        last  <= gnt;
                        if (sel_err) begin
                            rsp_data   <= '0;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                            rsp0_valid <= ~gnt;
                            rsp1_valid <= gnt;
                        end else begin
                            alu_a   <= sel_a;
                            alu_b   <= sel_b;
                            alu_fun <= sel_fun;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                CAPT: begin
                    rsp_data   <= bus.ALU_OUT;
                    rsp_flags  <= {carry_m, bus.ALU_ARITH, bus.ALU_LOGIC, bus.ALU_CMP, bus.ALU_SHIFT};
                    alu_fun    <= NOP_FUN;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.REQ0_READY = ready0;
    assign bus.REQ1_READY = ready1;
    assign bus.RSP0_VALID = rsp0_valid;
    assign bus.RSP1_VALID = rsp1_valid;
    assign bus.RSP_DATA   = rsp_data;
    assign bus.RSP_FLAGS  = rsp_flags;
    assign bus.RSP_ERR    = rsp_err;
    assign bus.ALU_A      = alu_a;
    assign bus.ALU_B      = alu_b;
    assign bus.ALU_FUN    = alu_fun;
    assign bus.BUSY       = (state != IDLE);
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a registered ALU model and a cycle-level
// behavioural reference for arbitration, latency and response contents.
module tb_alu_req_arbiter;
    typedef struct packed {
        logic        err;
        logic [4:0]  flags;
        logic [15:0] data;
    } rsp_t;

    localparam logic [3:0] NOP = 4'hF;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    alu_req_arbiter_if #(.WIDTH(16), .FUN_W(4)) bus ();

    alu_req_arbiter #(.WIDTH(16), .FUN_W(4), .NOP_FUN(4'hF)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rsp_t q0[$];
    rsp_t q1[$];
    int   grant_log[$];
    rsp_t last_rsp;
    int   last_port;
    bit   chk_en = 1'b0;
    bit   rnd_on = 1'b0;

    bit          m_busy  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    int          m_due   = 0;
    logic [15:0] m_a, m_b;
    logic [3:0]  m_f;

    always @(posedge CLK) cyc <= cyc + 1;

    // ALU result word: {carry, arith, logic, cmp, shift, data}
    function automatic logic [20:0] alu_calc(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] d;
        logic [4:0]  fl;
        w  = '0;
        p  = '0;
        d  = '0;
        fl = '0;
        case (f)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; d = w[15:0]; fl = {w[16], 4'b1000}; end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; d = w[15:0]; fl = {w[16], 4'b1000}; end
            4'd2: begin p = a * b; d = p[15:0]; fl = 5'b01000; end
            4'd3: begin d = (b != 0) ? a / b : 16'hFFFF; fl = 5'b01000; end
            4'd4: begin d = a & b; fl = 5'b00100; end
            4'd5: begin d = a | b; fl = 5'b00100; end
            4'd6: begin d = a ^ b; fl = 5'b00100; end
            4'd7: begin d = {15'd0, a < b}; fl = 5'b00010; end
            4'd8: begin d = a << b[3:0]; fl = 5'b00001; end
            4'd9: begin d = a >> b[3:0]; fl = 5'b00001; end
            default: begin d = '0; fl = '0; end
        endcase
        return {fl, d};
    endfunction

    function automatic rsp_t ref_rsp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        rsp_t        r;
        logic [20:0] x;
        if ((f == 4'd3 && b == 16'd0) || f == 4'hF) begin
            r = '{err: 1'b1, flags: 5'd0, data: 16'd0};
        end else begin
            x = alu_calc(a, b, f);
            r.err   = 1'b0;
            r.data  = x[15:0];
            r.flags = x[20:16];
            if (!(f == 4'd0 || f == 4'd1)) r.flags[4] = 1'b0;
        end
        return r;
    endfunction

    // Registered ALU; its carry only updates on add/sub and is otherwise stale.
    logic [20:0] alu_now, alu_reg;
    logic        alu_carry_reg;
    assign alu_now = alu_calc(bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
    always @(posedge CLK) begin
        alu_reg <= alu_now;
        if (RST) alu_carry_reg <= 1'b0;
        else if (bus.ALU_FUN == 4'd0 || bus.ALU_FUN == 4'd1) alu_carry_reg <= alu_now[20];
    end
    assign bus.ALU_OUT   = alu_reg[15:0];
    assign bus.ALU_CARRY = alu_carry_reg;
    assign bus.ALU_ARITH = alu_reg[19];
    assign bus.ALU_LOGIC = alu_reg[18];
    assign bus.ALU_CMP   = alu_reg[17];
    assign bus.ALU_SHIFT = alu_reg[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        bit   ev0, ev1, v0, v1, g, er0, er1, hold_v, acked;
        rsp_t cur, hold, exp_r, nr;
        hold_v = 1'b0;
        hold   = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_busy = 1'b0;
                m_last = 1'b1;
                hold_v = 1'b0;
            end else if (chk_en) begin
                ev0 = m_busy && (cyc >= m_due) && !m_owner;
                ev1 = m_busy && (cyc >= m_due) && m_owner;
                check("rsp0_valid", 32'(bus.RSP0_VALID), 32'(ev0));
                check("rsp1_valid", 32'(bus.RSP1_VALID), 32'(ev1));
                check("busy", 32'(bus.BUSY), 32'(m_busy));
                if (m_busy && cyc < m_due) begin
                    check("alu_fun_op", 32'(bus.ALU_FUN), 32'(m_f));
                    check("alu_a", 32'(bus.ALU_A), 32'(m_a));
                    check("alu_b", 32'(bus.ALU_B), 32'(m_b));
                end else begin
                    check("alu_fun_nop", 32'(bus.ALU_FUN), 32'(NOP));
                end
                if (bus.RSP0_VALID || bus.RSP1_VALID) begin
                    cur   = {bus.RSP_ERR, bus.RSP_FLAGS, bus.RSP_DATA};
                    acked = bus.RSP1_VALID ? bus.RSP1_READY : bus.RSP0_READY;
                    if (!hold_v) begin
                        if ((bus.RSP1_VALID && q1.size() == 0) || (!bus.RSP1_VALID && q0.size() == 0)) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp: got response %h, want none queued", cur);
                        end else begin
                            if (bus.RSP1_VALID) exp_r = q1.pop_front();
                            else                exp_r = q0.pop_front();
                            check("rsp_payload", 32'(cur), 32'(exp_r));
                            last_rsp  = cur;
                            last_port = bus.RSP1_VALID ? 1 : 0;
                        end
                    end else begin
                        check("rsp_stable", 32'(cur), 32'(hold));
                    end
                    hold   = cur;
                    hold_v = !acked;
                end else begin
                    hold_v = 1'b0;
                end
                v0  = bus.REQ0_VALID;
                v1  = bus.REQ1_VALID;
                g   = (v0 && v1) ? !m_last : v1;
                er0 = !m_busy && (v0 || v1) && !g;
                er1 = !m_busy && (v0 || v1) && g;
                check("req0_ready", 32'(bus.REQ0_READY), 32'(er0));
                check("req1_ready", 32'(bus.REQ1_READY), 32'(er1));
                if ((ev0 && bus.RSP0_READY) || (ev1 && bus.RSP1_READY)) begin
                    m_busy = 1'b0;
                end else if (!m_busy && (v0 || v1)) begin
                    m_busy  = 1'b1;
                    m_owner = g;
                    m_last  = g;
                    m_a     = g ? bus.REQ1_A : bus.REQ0_A;
                    m_b     = g ? bus.REQ1_B : bus.REQ0_B;
                    m_f     = g ? bus.REQ1_FUN : bus.REQ0_FUN;
                    nr      = ref_rsp(m_a, m_b, m_f);
                    m_due   = cyc + 1 + (nr.err ? 0 : 2);
                end
            end
        end
    end

    task automatic issue(input bit p, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        bit ok = 1'b0;
        if (!p) begin
            bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_FUN = f; bus.REQ0_VALID = 1'b1;
        end else begin
            bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_FUN = f; bus.REQ1_VALID = 1'b1;
        end
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge CLK);
            if (p ? bus.REQ1_READY : bus.REQ0_READY) begin
                ok = 1'b1;
                if (!p) q0.push_back(ref_rsp(a, b, f));
                else    q1.push_back(ref_rsp(a, b, f));
                grant_log.push_back(p ? 1 : 0);
            end
        end
        @(posedge CLK);
        #1;
        if (!p) bus.REQ0_VALID = 1'b0;
        else    bus.REQ1_VALID = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: port %0d got no READY, want READY within 300 cycles", p);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge CLK);
            #1;
            done = !m_busy && q0.size() == 0 && q1.size() == 0;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0d q0=%0d q1=%0d, want idle with empty queues", m_busy, q0.size(), q1.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge CLK);
        check({tag, "_alu_a"}, 32'(bus.ALU_A), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.ALU_B), 32'd0);
        check({tag, "_alu_fun"}, 32'(bus.ALU_FUN), 32'(NOP));
        check({tag, "_rsp_data"}, 32'(bus.RSP_DATA), 32'd0);
        check({tag, "_rsp_flags"}, 32'(bus.RSP_FLAGS), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.RSP_ERR), 32'd0);
        check({tag, "_rsp_valids"}, 32'({bus.RSP0_VALID, bus.RSP1_VALID}), 32'd0);
        check({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        q0.delete();
        q1.delete();
        grant_log.delete();
    endtask

    task automatic rand_driver(input bit p, input int count);
        logic [15:0] b;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
            b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            issue(p, 16'($urandom), b, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, want finish within time limit");
        $fatal(1);
    end

    initial begin
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        bus.REQ0_A = '0; bus.REQ0_B = '0; bus.REQ0_FUN = '0;
        bus.REQ1_A = '0; bus.REQ1_B = '0; bus.REQ1_FUN = '0;
        bus.RSP0_READY = 1'b1; bus.RSP1_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_reset_vals("por");
        chk_en = 1'b1;

        // Single add on port 0
        issue(0, 16'h0003, 16'h0004, 4'b0000);
        wait_idle();
        check("add_port", 32'(last_port), 32'd0);
        check("add_rsp", 32'(last_rsp), 32'({1'b0, 5'b01000, 16'h0007}));

        // Both ports pending continuously after reset
        do_reset();
        check_reset_vals("rst2");
        fork
            for (int i = 0; i < 4; i++) issue(0, 16'($urandom), 16'($urandom_range(1, 65535)), 4'($urandom_range(0, 9)));
            for (int i = 0; i < 4; i++) issue(1, 16'($urandom), 16'($urandom_range(1, 65535)), 4'($urandom_range(0, 9)));
        join
        wait_idle();
        check("rr_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(i % 2));

        // Carry reported on add, masked on a later logic op
        issue(1, 16'hFFFF, 16'h0001, 4'b0000);
        wait_idle();
        check("carry_add", 32'(last_rsp), 32'({1'b0, 5'b11000, 16'h0000}));
        issue(1, 16'hFFFF, 16'h0001, 4'b0100);
        wait_idle();
        check("carry_masked", 32'(last_rsp), 32'({1'b0, 5'b00100, 16'h0001}));

        // Rejected commands
        issue(0, 16'h1234, 16'h0000, 4'b0011);
        wait_idle();
        check("err_div0", 32'(last_rsp), 32'({1'b1, 5'b00000, 16'h0000}));
        issue(0, 16'h55AA, 16'h0002, 4'b1111);
        wait_idle();
        check("err_badop", 32'(last_rsp), 32'({1'b1, 5'b00000, 16'h0000}));

        // Response back-pressure with a competing request
        bus.RSP0_READY = 1'b0;
        issue(0, 16'h0005, 16'h0006, 4'b0010);
        fork
            issue(1, 16'h0007, 16'h0008, 4'b0101);
            begin
                repeat (8) @(negedge CLK);
                check("stall_rsp0_valid", 32'(bus.RSP0_VALID), 32'd1);
                check("stall_rsp0_data", 32'(bus.RSP_DATA), 32'h001E);
                check("stall_req1_ready", 32'(bus.REQ1_READY), 32'd0);
                @(posedge CLK);
                #1;
                bus.RSP0_READY = 1'b1;
            end
        join
        wait_idle();
        check("stall_after_port", 32'(last_port), 32'd1);
        check("stall_after_rsp", 32'(last_rsp), 32'({1'b0, 5'b00100, 16'h000F}));

        // Reset while the ALU is executing
        issue(0, 16'h0009, 16'h0009, 4'b0000);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        q0.delete();
        q1.delete();
        check_reset_vals("mid");
        repeat (6) @(negedge CLK);
        @(posedge CLK);
        #1;
        issue(0, 16'h0003, 16'h0004, 4'b0000);
        wait_idle();
        check("post_reset_rsp", 32'(last_rsp), 32'({1'b0, 5'b01000, 16'h0007}));

        // Random traffic on both ports with random response back-pressure
        rnd_on = 1'b1;
        fork
            begin
                fork
                    rand_driver(0, 40);
                    rand_driver(1, 40);
                join
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge CLK);
                #1;
                bus.RSP0_READY = ($urandom_range(0, 2) != 0);
                bus.RSP1_READY = ($urandom_range(0, 2) != 0);
            end
        join
        bus.RSP0_READY = 1'b1;
        bus.RSP1_READY = 1'b1;
        wait_idle();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
